hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 33 +++
 rtl/sat_counter16.sv | 28 ++
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: state encoding,
// default memory timeout, output bundle and the load-use detector.
package hazard_ctrl_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_REDIRECT = 2'd1;
  localparam logic [1:0] ST_MEMWAIT  = 2'd2;

  localparam int MEM_TIMEOUT_DEFAULT = 15;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_hold;
  } hz_ctrl_t;

  // A load that writes a non-zero register read by the following instruction.
  function automatic logic load_use(
    input logic       memtoreg,
    input logic       regwr,
    input logic [4:0] idex_rt,
    input logic [4:0] ifid_rs,
    input logic [4:0] ifid_rt,
    input logic       uses_rt
  );
    logic hit;
    hit = (idex_rt == ifid_rs) || (uses_rt && (idex_rt == ifid_rt));
    return memtoreg && regwr && (idex_rt != 5'd0) && hit;
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit counter that advances on enable, sticks at all-ones and clears
// synchronously; clear wins over enable. Updates on the falling clock edge.
module sat_counter16 (
  input  logic        clk_i,
  input  logic        clr_i,
  input  logic        en_i,
  output logic [15:0] cnt_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 16'h0000;
    end else if (en_i && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(negedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump redirect flushes,
// data-memory freeze with sticky timeout, and stall/flush performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [4:0]  IfId_Rs,
  input  logic [4:0]  IfId_Rt,
  input  logic        IfId_UsesRt,
  input  logic [4:0]  IdEx_Rt,
  input  logic        IdEx_MemtoReg,
  input  logic        IdEx_RegWr,
  input  logic        IdEx_Jump,
  input  logic        Ex_BranchTaken,
  input  logic        Mem_Busy,
  output logic        PC_Write,
  output logic        IfId_Write,
  output logic        IfId_Flush,
  output logic        IdEx_Flush,
  output logic        ExMem_Hold,
  output logic        Mem_Timeout,
  output logic [15:0] Stall_Cnt,
  output logic [15:0] Flush_Cnt,
  output logic [1:0]  Dbg_State
);

  logic [1:0] state_q, state_d;
  logic [3:0] busy_q, busy_d;
  logic       timeout_q, timeout_d;
  hz_ctrl_t   ctrl;
  logic       lu;
  logic       rd;
  logic       redirect_enter;
  logic       mem_wait_busy;
  logic       busy_hit;

  assign lu = load_use(IdEx_MemtoReg, IdEx_RegWr, IdEx_Rt, IfId_Rs, IfId_Rt, IfId_UsesRt);
  assign rd = Ex_BranchTaken | IdEx_Jump;

  // Priority Reset > Mem_Busy > state-specific decode. The cycle that leaves
  // MEMWAIT decodes exactly like RUN so a held RD or LU is acted on at once.
  always_comb begin
    ctrl           = '0;
    state_d        = state_q;
    redirect_enter = 1'b0;
    if (Reset) begin
      ctrl.ifid_flush = 1'b1;
      ctrl.idex_flush = 1'b1;
      state_d         = ST_RUN;
    end else if (Mem_Busy) begin
      ctrl.exmem_hold = 1'b1;
      state_d         = ST_MEMWAIT;
    end else if (state_q == ST_REDIRECT) begin
      ctrl.pc_write   = 1'b1;
      ctrl.ifid_write = 1'b1;
      ctrl.ifid_flush = 1'b1;
      state_d         = rd ? ST_REDIRECT : ST_RUN;
    end else begin
      state_d = ST_RUN;
      if (rd) begin
        ctrl.pc_write   = 1'b1;
        ctrl.ifid_write = 1'b1;
        ctrl.ifid_flush = 1'b1;
        ctrl.idex_flush = 1'b1;
        state_d         = ST_REDIRECT;
        redirect_enter  = 1'b1;
      end else if (lu) begin
        ctrl.idex_flush = 1'b1;
      end else begin
        ctrl.pc_write   = 1'b1;
        ctrl.ifid_write = 1'b1;
      end
    end
  end

  // Busy count tracks consecutive MEMWAIT cycles that are still busy; the
  // timeout trips on the cycle that would make it reach MEM_TIMEOUT.
  assign mem_wait_busy = (state_q == ST_MEMWAIT) && Mem_Busy;
  assign busy_hit      = (int'(busy_q) + 1) >= MEM_TIMEOUT;

  always_comb begin
    busy_d    = 4'd0;
    timeout_d = timeout_q;
    if (Reset) begin
      timeout_d = 1'b0;
    end else if (mem_wait_busy) begin
      busy_d = (busy_q == 4'hF) ? busy_q : busy_q + 4'd1;
      if (busy_hit) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(negedge clk) begin
    if (Reset) begin
      state_q   <= ST_RUN;
      busy_q    <= 4'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter16 u_stall_cnt (
    .clk_i (clk),
    .clr_i (Reset),
    .en_i  (~ctrl.pc_write),
    .cnt_o (Stall_Cnt)
  );

  sat_counter16 u_flush_cnt (
    .clk_i (clk),
    .clr_i (Reset),
    .en_i  (redirect_enter),
    .cnt_o (Flush_Cnt)
  );

  assign PC_Write    = ctrl.pc_write;
  assign IfId_Write  = ctrl.ifid_write;
  assign IfId_Flush  = ctrl.ifid_flush;
  assign IdEx_Flush  = ctrl.idex_flush;
  assign ExMem_Hold  = ctrl.exmem_hold;
  assign Mem_Timeout = timeout_q;
  assign Dbg_State   = state_q;

endmodule
